instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
Streaming instruction encoder and loader. It is the producing end of the control decoder's instruction-field interface. It accepts field-level instruction descriptions (cond, Op, Funct, Rn, Rd, Src2/Imm24) over a valid/ready handshake. Each description is packed into a 32-bit ARM-format word and written sequentially into instruction memory starting at a programmable base address. It is used to preload programs before the core leaves reset.

Parameters:
ADDR_W, 8, byte-address width of instruction memory; addresses are word-aligned, step 4.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset (reset=0 resets on next rising clk)
start  input  1  begin a load session; sampled only in IDLE
base_addr  input  ADDR_W  first write address; bits [1:0] forced to 0
in_valid  input  1  field bundle valid
in_ready  output  1  encoder accepts bundle this cycle
in_last  input  1  bundle is final instruction of the session
in_cond  input  4  condition field
in_op  input  2  Op field (00 DP, 01 mem, 10 branch, 11 illegal)
in_funct  input  6  Funct field
in_rn  input  4  Rn
in_rd  input  4  Rd
in_src  input  24  Src2 in [11:0] for Op 00/01; Imm24 for Op 10
mem_we  output  1  instruction-memory write strobe
mem_addr  output  ADDR_W  write byte address
mem_wdata  output  32  encoded instruction
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse at session end
err  output  1  sticky: an illegal Op was dropped this session
full  output  1  sticky: top word address written, session truncated
word_count  output  ADDR_W-1  words written this session

Behaviour:
- Reset values: FSM=IDLE. in_ready, mem_we, busy, done, err and full are 0. mem_addr, mem_wdata and word_count are 0.
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE: busy=0, in_ready=0. When start=1:
  - addr_q <= {base_addr[ADDR_W-1:2],2'b00}.
  - word_count, err and full <= 0.
  - Next state ACCEPT.
- ACCEPT: in_ready=1. A handshake is in_valid & in_ready.
  - On a handshake with in_op != 11: latch the encoded word and in_last, then go to WRITE.
  - On a handshake with in_op == 11: no write; err <= 1. If in_last, go to DONE; otherwise stay in ACCEPT.
- Encoding:
  - Op 00 or 01: {cond, op, funct, rn, rd, src[11:0]}; in_src[23:12] is ignored.
  - Op 10: {cond, 2'b10, funct[5:4], src[23:0]}; rn, rd and funct[3:0] are ignored.
- WRITE: in_ready=0, mem_we=1 for exactly one cycle, mem_addr=addr_q, mem_wdata=latched word.
  - On exit: word_count += 1 and addr_q += 4.
  - If addr_q equals 2^ADDR_W-4: full <= 1, next state DONE. The address never wraps.
  - Otherwise, if the latched last flag is set, next state DONE.
  - Otherwise, next state ACCEPT.
- DONE: done=1 for one cycle, busy=1, next state IDLE. err, full and word_count hold until the next start.
- Throughput is 2 cycles per legal instruction: one accept cycle, one write cycle.
- mem_addr and mem_wdata are registered and hold their last value when mem_we=0.
- start is ignored outside IDLE.
- Reset asserted mid-session: abort immediately with no further write. A mem_we in the reset cycle is suppressed on the next edge. All outputs return to reset values.
- full takes priority over in_last. If both apply, there is a single DONE.

Test Plan:
- Reset=0 for 2 cycles, then release -> all outputs 0, busy=0, in_ready=0.
- start, base_addr=0x10; one bundle: cond=1110, op=00, funct=101000, rn=2, rd=1, src=0x005, in_last=1 -> mem_we at addr 0x10, wdata 0xE2821005; done pulse 1 cycle later; word_count=1, err=0.
- Back-to-back session at base 0x00 with three bundles, in_valid held high:
  - LDR: op=01, funct=011001, rn=0, rd=3, src=0x008 -> 0xE5903008 at 0x00.
  - Branch: op=10, funct=10xxxx, src=0xFFFFFE -> 0xEAFFFFFE at 0x04.
  - Third bundle has op=11 and in_last=1 -> no write, err=1, done, word_count=2.
- ADDR_W=8, base_addr=0xF8, three bundles with no in_last -> writes at 0xF8 and 0xFC, then full=1, done, in_ready low. The third bundle is never accepted.
- in_valid toggled 1/0 randomly during ACCEPT -> writes only on handshake cycles, at consecutive addresses, with no duplicated or lost words.
- Reset pulled low in the WRITE cycle of the second word -> at most one completed write beyond the first. On release, state is IDLE, word_count=0, and start still works.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Field-level instruction bundle handshake between a program source and instr_encoder.
interface instr_encoder_if;
    localparam int unsigned COND_W  = 4;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned SRC_W   = 24;

    logic               in_valid;
    logic               in_ready;
    logic               in_last;
    logic [COND_W-1:0]  in_cond;
    logic [OP_W-1:0]    in_op;
    logic [FUNCT_W-1:0] in_funct;
    logic [REG_W-1:0]   in_rn;
    logic [REG_W-1:0]   in_rd;
    logic [SRC_W-1:0]   in_src;

    modport master (
        output in_valid, in_last, in_cond, in_op, in_funct, in_rn, in_rd, in_src,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_last, in_cond, in_op, in_funct, in_rn, in_rd, in_src,
        output in_ready
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs field-level instruction bundles into 32-bit ARM words and writes them
// sequentially into instruction memory from a programmable base address.
module instr_encoder #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    instr_encoder_if.slave      in_if,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [31:0]         mem_wdata,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                full,
    output logic [ADDR_W-2:0]   word_count
);
    localparam int unsigned CNT_W = ADDR_W - 1;
    localparam logic [ADDR_W-1:0] ADDR_TOP = ~ADDR_W'(3);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_last;
    logic                r_in_ready;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                r_full;
    logic [CNT_W-1:0]    r_count;

    logic                w_hs;
    logic                w_legal;
    logic                w_top;
    logic [31:0]         w_enc;

    assign w_hs    = in_if.in_valid & r_in_ready;
    assign w_legal = (in_if.in_op != 2'b11);
    assign w_top   = (r_addr == ADDR_TOP);

    // Branches carry a 24-bit immediate and only the top two funct bits.
    always_comb begin
        w_enc = {in_if.in_cond, in_if.in_op, in_if.in_funct,
                 in_if.in_rn, in_if.in_rd, in_if.in_src[11:0]};
        if (in_if.in_op == 2'b10) begin
            w_enc = {in_if.in_cond, 2'b10, in_if.in_funct[5:4], in_if.in_src};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Full (top word written) wins over the last flag on exit from WRITE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_ACCEPT;
            S_ACCEPT: begin
                if (w_hs) begin
                    if (w_legal)             w_next = S_WRITE;
                    else if (in_if.in_last)  w_next = S_DONE;
                end
            end
            S_WRITE:  begin
                if (w_top || r_last) w_next = S_DONE;
                else                 w_next = S_ACCEPT;
            end
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_addr      <= '0;
            r_last      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_full      <= 1'b0;
            r_count     <= '0;
        end else begin
            r_in_ready <= (w_next == S_ACCEPT);
            r_mem_we   <= (w_next == S_WRITE);
            r_busy     <= (w_next != S_IDLE);
            r_done     <= (w_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr  <= base_addr & ~ADDR_W'(3);
                        r_count <= '0;
                        r_err   <= 1'b0;
                        r_full  <= 1'b0;
                    end
                end
                S_ACCEPT: begin
                    if (w_hs) begin
                        if (w_legal) begin
                            r_mem_addr  <= r_addr;
                            r_mem_wdata <= w_enc;
                            r_last      <= in_if.in_last;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    r_count <= r_count + CNT_W'(1);
                    if (w_top) r_full <= 1'b1;
                    else       r_addr <= r_addr + ADDR_W'(4);
                end
                default: ;
            endcase
        end
    end

    assign in_if.in_ready = r_in_ready;
    assign mem_we         = r_mem_we;
    assign mem_addr       = r_mem_addr;
    assign mem_wdata      = r_mem_wdata;
    assign busy           = r_busy;
    assign done           = r_done;
    assign err            = r_err;
    assign full           = r_full;
    assign word_count     = r_count;
endmodule

// File: tb/tb_instr_encoder.sv
// Randomized self-checking bench for instr_encoder against a session-level reference model.
module tb_instr_encoder;
    localparam int unsigned ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy, done, err, full;
    logic [ADDR_W-2:0] word_count;

    instr_encoder_if bus();

    instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .in_if      (bus),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .full       (full),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cond;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [23:0] src;
        bit          last;
    } bundle_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    int  checks = 0;
    int  failures = 0;
    wr_t got_q[$];
    wr_t exp_q[$];
    wr_t mon_w;
    int  done_seen = 0;
    int  exp_cnt;
    bit  exp_err;
    bit  exp_full;
    int  consumed;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Word layout from the ARM field rules, written as plain arithmetic.
    function automatic logic [31:0] ref_encode(input bundle_t b);
        if (b.op == 2'b10)
            return (32'(b.cond) << 28) | (32'd2 << 26) | (32'(b.funct / 6'd16) << 24) | 32'(b.src);
        return (32'(b.cond) << 28) | (32'(b.op) << 26) | (32'(b.funct) << 20)
             | (32'(b.rn) << 16) | (32'(b.rd) << 12) | (32'(b.src) % 32'd4096);
    endfunction

    // Expected writes and final status for a whole session.
    task automatic ref_session(input logic [7:0] base, input bundle_t bq[$]);
        int unsigned a;
        wr_t w;
        a = 32'(base) - (32'(base) % 4);
        exp_q.delete();
        exp_cnt = 0; exp_err = 0; exp_full = 0; consumed = 0;
        foreach (bq[i]) begin
            consumed = i + 1;
            if (bq[i].op == 2'b11) begin
                exp_err = 1;
                if (bq[i].last) break;
            end else begin
                w.addr = 8'(a);
                w.data = ref_encode(bq[i]);
                exp_q.push_back(w);
                exp_cnt++;
                if (a == (1 << ADDR_W) - 4) begin
                    exp_full = 1;
                    break;
                end
                a += 4;
                if (bq[i].last) break;
            end
        end
    endtask

    function automatic bundle_t mk(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                                   input logic [3:0] n, input logic [3:0] d, input logic [23:0] s,
                                   input bit l);
        bundle_t b;
        b.cond = c; b.op = o; b.funct = f; b.rn = n; b.rd = d; b.src = s; b.last = l;
        return b;
    endfunction

    function automatic bundle_t rnd_bundle(input bit l);
        return mk(4'($urandom), 2'($urandom_range(0, 3)), 6'($urandom), 4'($urandom),
                  4'($urandom), 24'($urandom), l);
    endfunction

    always @(negedge clk) begin
        if (mem_we) begin
            mon_w.addr = mem_addr;
            mon_w.data = mem_wdata;
            got_q.push_back(mon_w);
        end
        if (done) done_seen++;
    end

    task automatic apply(input bundle_t b);
        bus.in_cond = b.cond; bus.in_op = b.op; bus.in_funct = b.funct;
        bus.in_rn = b.rn; bus.in_rd = b.rd; bus.in_src = b.src; bus.in_last = b.last;
    endtask

    // Present one bundle (optionally after idle gaps); returns on the negedge after acceptance.
    task automatic send(input bundle_t b, input bit gaps);
        bit ok;
        ok = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
            end
        end
        apply(b);
        bus.in_valid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if (bus.in_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check_eq("accept_timeout", 64'(0), 64'(1));
        @(negedge clk);
    endtask

    task automatic run_session(input logic [7:0] base, input bundle_t bq[$], input bit gaps,
                               input string name);
        int t;
        got_q.delete();
        done_seen = 0;
        ref_session(base, bq);
        start = 1'b1;
        base_addr = base;
        @(negedge clk);
        start = 1'b0;
        base_addr = 8'($urandom);
        for (int i = 0; i < consumed; i++) send(bq[i], gaps);
        if (consumed < bq.size()) begin
            apply(bq[consumed]);
            bus.in_valid = 1'b1;
        end else begin
            bus.in_valid = 1'b0;
        end
        for (t = 0; t < 20 && !done; t++) @(negedge clk);
        check_eq({name, ".done"}, 64'(done), 64'(1));
        check_eq({name, ".busy_done"}, 64'(busy), 64'(1));
        check_eq({name, ".ready_done"}, 64'(bus.in_ready), 64'(0));
        check_eq({name, ".count"}, 64'(word_count), 64'(exp_cnt));
        check_eq({name, ".err"}, 64'(err), 64'(exp_err));
        check_eq({name, ".full"}, 64'(full), 64'(exp_full));
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_eq({name, ".done_pulse"}, 64'(done), 64'(0));
        check_eq({name, ".busy_idle"}, 64'(busy), 64'(0));
        check_eq({name, ".ndone"}, 64'(done_seen), 64'(1));
        check_eq({name, ".nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < got_q.size()) begin
                check_eq($sformatf("%s.addr%0d", name, i), 64'(got_q[i].addr), 64'(exp_q[i].addr));
                check_eq($sformatf("%s.data%0d", name, i), 64'(got_q[i].data), 64'(exp_q[i].data));
            end
        end
    endtask

    task automatic check_reset_state(input string name);
        check_eq({name, ".we"}, 64'(mem_we), 64'(0));
        check_eq({name, ".addr"}, 64'(mem_addr), 64'(0));
        check_eq({name, ".wdata"}, 64'(mem_wdata), 64'(0));
        check_eq({name, ".busy"}, 64'(busy), 64'(0));
        check_eq({name, ".done"}, 64'(done), 64'(0));
        check_eq({name, ".err"}, 64'(err), 64'(0));
        check_eq({name, ".full"}, 64'(full), 64'(0));
        check_eq({name, ".count"}, 64'(word_count), 64'(0));
        check_eq({name, ".ready"}, 64'(bus.in_ready), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bundle_t bq[$];
        bundle_t b1, b2;
        int n;
        logic [7:0] base;

        bus.in_valid = 1'b0;
        apply(mk(4'h0, 2'b00, 6'h0, 4'h0, 4'h0, 24'h0, 1'b0));
        repeat (2) @(negedge clk);
        check_reset_state("rst");
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("rst_rel");

        // Single ADD at 0x10.
        bq.delete();
        bq.push_back(mk(4'hE, 2'b00, 6'b101000, 4'd2, 4'd1, 24'h000005, 1'b1));
        run_session(8'h10, bq, 1'b0, "t1");
        if (got_q.size() > 0) begin
            check_eq("t1.word_const", 64'(got_q[0].data), 64'(32'hE2821005));
            check_eq("t1.addr_const", 64'(got_q[0].addr), 64'(8'h10));
        end

        // LDR, branch, then an illegal op flagged last.
        bq.delete();
        bq.push_back(mk(4'hE, 2'b01, 6'b011001, 4'd0, 4'd3, 24'h000008, 1'b0));
        bq.push_back(mk(4'hE, 2'b10, 6'h20 | 6'($urandom_range(0, 15)), 4'($urandom),
                        4'($urandom), 24'hFFFFFE, 1'b0));
        bq.push_back(mk(4'hE, 2'b11, 6'h0, 4'h0, 4'h0, 24'h0, 1'b1));
        run_session(8'h00, bq, 1'b0, "t2");
        if (got_q.size() > 1) begin
            check_eq("t2.ldr_const", 64'(got_q[0].data), 64'(32'hE5903008));
            check_eq("t2.b_const", 64'(got_q[1].data), 64'(32'hEAFFFFFE));
        end
        check_eq("t2.err_const", 64'(err), 64'(1));
        check_eq("t2.count_const", 64'(word_count), 64'(2));

        // Top of memory: session truncated after 0xFC.
        bq.delete();
        for (int i = 0; i < 3; i++)
            bq.push_back(mk(4'($urandom), 2'($urandom_range(0, 1)), 6'($urandom), 4'($urandom),
                            4'($urandom), 24'($urandom), 1'b0));
        run_session(8'hF8, bq, 1'b0, "t3");
        check_eq("t3.full_const", 64'(full), 64'(1));
        check_eq("t3.count_const", 64'(word_count), 64'(2));
        repeat (3) begin
            check_eq("t3.ready_idle", 64'(bus.in_ready), 64'(0));
            @(negedge clk);
        end

        // Random sessions with gapped valid, including unaligned and near-top bases.
        for (int s = 0; s < 14; s++) begin
            bq.delete();
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) bq.push_back(rnd_bundle(i == n - 1));
            base = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(8'hE0, 8'hFF))
                                               : 8'($urandom);
            run_session(base, bq, 1'b1, $sformatf("rnd%0d", s));
        end

        // Reset during the write cycle of the second word.
        got_q.delete();
        b1 = mk(4'hE, 2'b00, 6'($urandom), 4'($urandom), 4'($urandom), 24'($urandom), 1'b0);
        b2 = mk(4'hA, 2'b01, 6'($urandom), 4'($urandom), 4'($urandom), 24'($urandom), 1'b0);
        start = 1'b1;
        base_addr = 8'h40;
        @(negedge clk);
        start = 1'b0;
        send(b1, 1'b0);
        send(b2, 1'b0);
        check_eq("t5.we_pre", 64'(mem_we), 64'(1));
        reset = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_reset_state("t5.rst");
        check_eq("t5.nwr_ok", 64'(got_q.size() >= 1 && got_q.size() <= 2), 64'(1));
        if (got_q.size() > 0) begin
            check_eq("t5.addr0", 64'(got_q[0].addr), 64'(8'h40));
            check_eq("t5.data0", 64'(got_q[0].data), 64'(ref_encode(b1)));
        end
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("t5.rel");
        bq.delete();
        bq.push_back(rnd_bundle(1'b0));
        bq[0].op = 2'b10;
        bq.push_back(rnd_bundle(1'b1));
        run_session(8'h21, bq, 1'b1, "t5.post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
